// File: rtl/window_3x3_gen_pkg.sv
// Shared types for the 3x3 filter chain: pixel width, packed window width and
// window pack/unpack helpers (p00 in the MSBs, p22 in the LSBs, row-major).
package window_3x3_gen_pkg;

   localparam int PIXEL_W = 8;
   localparam int WIN_W   = 9 * PIXEL_W;

   typedef logic [PIXEL_W-1:0] pixel_t;
   // Ascending indices make win[0][0] land in the MSBs when flattened.
   typedef logic [0:2][0:2][PIXEL_W-1:0] win_arr_t;

   function automatic logic [WIN_W-1:0] win_pack(input win_arr_t w);
      return w;
   endfunction

   function automatic win_arr_t win_unpack(input logic [WIN_W-1:0] v);
      return win_arr_t'(v);
   endfunction

endpackage

// File: rtl/window_3x3_gen_line_buffer.sv
// One-line pixel store: single address, write enable, combinational read that
// returns the pre-write contents during a write cycle.
module window_3x3_gen_line_buffer
   import window_3x3_gen_pkg::*;
#(
   parameter int DEPTH = 640,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  pixel_t        wr_data,
   output pixel_t        rd_data
);

   pixel_t mem [DEPTH];

   assign rd_data = mem[addr];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wr_data;
   end

endmodule

// File: rtl/window_3x3_gen.sv
// Raster pixel stream to 3x3 window converter; emits only windows lying fully
// inside the image, one clock after the pixel that completes them.
module window_3x3_gen
   import window_3x3_gen_pkg::*;
#(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       pixel_in,
   input  logic             pixel_in_valid,
   output logic [WIN_W-1:0] window_out,
   output logic             window_out_valid,
   output logic             frame_done
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0] COL_2    = CW'(2);
   localparam logic [RW-1:0] ROW_2    = RW'(2);

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   pixel_t        lb_a_rd, lb_b_rd;
   win_arr_t      win, win_nxt;
   logic          emit, last_px;

   // lb_a holds row r-1; its old value cascades into lb_b (row r-2).
   window_3x3_gen_line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb_a (
      .clk     (clk),
      .we      (pixel_in_valid),
      .addr    (col),
      .wr_data (pixel_in),
      .rd_data (lb_a_rd)
   );

   window_3x3_gen_line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb_b (
      .clk     (clk),
      .we      (pixel_in_valid),
      .addr    (col),
      .wr_data (lb_a_rd),
      .rd_data (lb_b_rd)
   );

   always_comb begin
      win_nxt = win;
      for (int r = 0; r < 3; r++) begin
         win_nxt[r][0] = win[r][1];
         win_nxt[r][1] = win[r][2];
      end
      win_nxt[0][2] = lb_b_rd;
      win_nxt[1][2] = lb_a_rd;
      win_nxt[2][2] = pixel_in;
   end

   assign emit    = pixel_in_valid && (row >= ROW_2) && (col >= COL_2);
   assign last_px = (row == ROW_LAST) && (col == COL_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         col              <= '0;
         row              <= '0;
         win              <= '0;
         window_out       <= '0;
         window_out_valid <= 1'b0;
         frame_done       <= 1'b0;
      end else begin
         window_out_valid <= emit;
         frame_done       <= pixel_in_valid && last_px;
         if (pixel_in_valid) begin
            win <= win_nxt;
            if (emit) window_out <= win_pack(win_nxt);
            if (col == COL_LAST) begin
               col <= '0;
               row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Randomized bench for window_3x3_gen: a frame-array reference model predicts
// every output cycle for a 5x5 and an 8x4 instance.
module tb_window_3x3_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  pixel_in;
   logic        pixel_in_valid;
   logic        sel;
   logic [71:0] wo5, wo8, window_out;
   logic        wv5, wv8, fd5, fd8, window_out_valid, frame_done;

   always #5 clk = ~clk;

   window_3x3_gen #(.IMG_WIDTH(5), .IMG_HEIGHT(5)) u_dut5 (
      .clk              (clk),
      .rst              (rst),
      .pixel_in         (pixel_in),
      .pixel_in_valid   (pixel_in_valid && !sel),
      .window_out       (wo5),
      .window_out_valid (wv5),
      .frame_done       (fd5)
   );

   window_3x3_gen #(.IMG_WIDTH(8), .IMG_HEIGHT(4)) u_dut8 (
      .clk              (clk),
      .rst              (rst),
      .pixel_in         (pixel_in),
      .pixel_in_valid   (pixel_in_valid && sel),
      .window_out       (wo8),
      .window_out_valid (wv8),
      .frame_done       (fd8)
   );

   assign window_out       = sel ? wo8 : wo5;
   assign window_out_valid = sel ? wv8 : wv5;
   assign frame_done       = sel ? fd8 : fd5;

   int checks = 0;
   int failures = 0;
   int W = 5, H = 5;
   int mr = 0, mc = 0;
   int wins = 0, fdones = 0;
   logic [7:0]  img [0:7][0:7];
   logic [71:0] e_win = '0;
   logic        e_vld, e_fd;
   logic [71:0] q_win [$];
   logic [71:0] q_ref [$];

   task automatic chk(input string tag, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask

   // One clock: drive, let the DUT sample, advance the model, compare.
   task automatic step(input logic v, input logic [7:0] p);
      pixel_in       = p;
      pixel_in_valid = v;
      @(posedge clk);
      #1;
      e_vld = 1'b0;
      e_fd  = 1'b0;
      if (rst) begin
         mr = 0; mc = 0; e_win = '0;
      end else if (v) begin
         img[mr][mc] = p;
         if (mr >= 2 && mc >= 2) begin
            e_vld = 1'b1;
            e_win = '0;
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  e_win = {e_win[63:0], img[mr-2+i][mc-2+j]};
         end
         e_fd = (mr == H-1 && mc == W-1);
         if (mc == W-1) begin
            mc = 0;
            mr = (mr == H-1) ? 0 : mr + 1;
         end else begin
            mc++;
         end
      end
      chk("valid", 72'(window_out_valid), 72'(e_vld));
      chk("frame_done", 72'(frame_done), 72'(e_fd));
      chk("window", window_out, e_win);
      if (window_out_valid) begin
         wins++;
         q_win.push_back(window_out);
      end
      if (frame_done) fdones++;
      pixel_in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b0, 8'h00);
      rst = 1'b0;
   endtask

   // Feeds n pixels of the current frame; idle_pct percent of cycles are gaps.
   task automatic feed(input int n, input logic [7:0] base, input int idle_pct, input bit rnd);
      logic [7:0] p;
      for (int k = 0; k < n; k++) begin
         while ($urandom_range(0, 99) < idle_pct) step(1'b0, 8'($urandom));
         p = rnd ? 8'($urandom) : (8'((mr << 4) | mc) + base);
         step(1'b1, p);
      end
   endtask

   task automatic start_test();
      wins = 0; fdones = 0;
      q_win.delete();
   endtask

   initial begin
      rst = 1'b1; sel = 1'b0; pixel_in = '0; pixel_in_valid = 1'b0;
      do_reset();
      step(1'b0, 8'h00);

      // 1: continuous 5x5 frame
      start_test();
      feed(25, 8'h00, 0, 0);
      step(1'b0, 8'h00);
      chk("t1_count", 72'(wins), 72'd9);
      chk("t1_first", q_win[0], 72'h00_01_02_10_11_12_20_21_22);
      chk("t1_last", q_win[$], 72'h22_23_24_32_33_34_42_43_44);
      chk("t1_fdone", 72'(fdones), 72'd1);
      q_ref = q_win;

      // 2: same image, random idle gaps
      start_test();
      feed(25, 8'h00, 40, 0);
      step(1'b0, 8'h00);
      chk("t2_count", 72'(wins), 72'd9);
      for (int k = 0; k < 9 && k < q_win.size(); k++) chk("t2_seq", q_win[k], q_ref[k]);

      // 3: two back-to-back frames, second offset by 8'h80
      start_test();
      feed(25, 8'h00, 0, 0);
      feed(25, 8'h80, 0, 0);
      step(1'b0, 8'h00);
      chk("t3_count", 72'(wins), 72'd18);
      chk("t3_fdone", 72'(fdones), 72'd2);
      if (q_win.size() > 9) chk("t3_f2_first", q_win[9], 72'h80_81_82_90_91_92_A0_A1_A2);
      else chk("t3_f2_first", 72'(q_win.size()), 72'd10);

      // 4: reset after accepting (3,1), then a fresh frame
      start_test();
      feed(17, 8'h00, 20, 0);
      do_reset();
      start_test();
      feed(25, 8'h40, 20, 0);
      step(1'b0, 8'h00);
      chk("t4_count", 72'(wins), 72'd9);
      if (q_win.size() > 0) chk("t4_first", q_win[0], 72'h40_41_42_50_51_52_60_61_62);
      else chk("t4_first", 72'd0, 72'd1);

      // 5: 8x4 instance with random data and gaps, two frames
      sel = 1'b1; W = 8; H = 4;
      do_reset();
      start_test();
      feed(32, 8'h00, 30, 1);
      step(1'b0, 8'h00);
      chk("t5_count", 72'(wins), 72'd12);
      feed(32, 8'h00, 0, 1);
      step(1'b0, 8'h00);
      chk("t5_count2", 72'(wins), 72'd24);
      chk("t5_fdone", 72'(fdones), 72'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
